// File: rtl/pc_gen_if.sv
// Handshake bundle between the fetch-control logic and pc_gen.
// The master side drives redirect/stall/RAS requests; the slave side (pc_gen) returns PC and RAS status.
interface pc_gen_if #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             flush_valid;
  logic [WIDTH-1:0] flush_target;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] pc_cur;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, flush_valid, flush_target, redirect_valid, redirect_target,
           ras_push, ras_pop,
    input  pc_cur, pc_next, ras_count, ras_empty, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, flush_valid, flush_target, redirect_valid, redirect_target,
           ras_push, ras_pop,
    output pc_cur, pc_next, ras_count, ras_empty, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with flush/redirect/stall priority and an optional circular
// return-address stack, compiled in only when PC_GEN_RAS_EN is defined.
module pc_gen #(
  parameter int WIDTH     = 16,
  parameter int INC       = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input logic    clk,
  input logic    reset_n,
  pc_gen_if.slave bus
);
  localparam int               CW    = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VEC);

  logic [WIDTH-1:0] pc_cur;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic             advance;

  assign pc_inc  = pc_cur + INC_W;
  assign advance = ~bus.flush_valid & ~bus.redirect_valid & ~bus.stall;

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;
  logic             ras_empty;
  logic             ras_full;
  logic             do_push;
  logic             do_pop;

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign do_push   = advance & bus.ras_push;
  assign do_pop    = advance & bus.ras_pop & ~ras_empty;
  // A push paired with a real pop replaces the top in place instead of growing the stack.
  assign wr_ptr    = do_pop ? top_ptr : top_ptr + PW'(1);

  always_comb begin
    pc_next = pc_inc;
    if (bus.flush_valid)         pc_next = bus.flush_target;
    else if (bus.redirect_valid) pc_next = bus.redirect_target;
    else if (bus.stall)          pc_next = pc_cur;
    else if (do_pop)             pc_next = ras_mem[top_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= do_push & ~do_pop & ras_full;
      ras_underflow <= advance & bus.ras_pop & ~bus.ras_push & ras_empty;
      if (do_push && !do_pop) begin
        top_ptr <= top_ptr + PW'(1);
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (do_pop && !do_push) begin
        top_ptr   <= top_ptr - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // Entry contents are never reset; they are hidden behind ras_count.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[wr_ptr] <= pc_inc;
  end

  assign bus.ras_count     = ras_count;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_overflow  = ras_overflow;
  assign bus.ras_underflow = ras_underflow;
`else
  logic unused_ras;

  assign unused_ras = bus.ras_push ^ bus.ras_pop ^ advance;

  always_comb begin
    pc_next = pc_inc;
    if (bus.flush_valid)         pc_next = bus.flush_target;
    else if (bus.redirect_valid) pc_next = bus.redirect_target;
    else if (bus.stall)          pc_next = pc_cur;
  end

  assign bus.ras_count     = '0;
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_cur <= RST_W;
    else          pc_cur <= pc_next;
  end

  assign bus.pc_cur  = pc_cur;
  assign bus.pc_next = pc_next;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a queue-based stack model predicts each cycle's outputs,
// a separate monitor compares them after every clock edge.
module tb_pc_gen;
  localparam int DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        emp;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t        sb[$];
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];

  pc_gen_if #(.WIDTH(16), .RAS_DEPTH(DEPTH)) bus ();

  pc_gen #(.WIDTH(16), .INC(1), .RESET_VEC(0), .RAS_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(bit f, logic [15:0] ft, bit r, logic [15:0] rt, bit s, bit pu, bit po);
    exp_t        e;
    logic [15:0] inc;
    logic [15:0] nxt;
    bit          adv;
    @(negedge clk);
    bus.flush_valid     = f;
    bus.flush_target    = ft;
    bus.redirect_valid  = r;
    bus.redirect_target = rt;
    bus.stall           = s;
    bus.ras_push        = pu;
    bus.ras_pop         = po;
    inc = m_pc + 16'd1;
    adv = !f && !r && !s;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (f)                                     nxt = ft;
    else if (r)                                nxt = rt;
    else if (s)                                nxt = m_pc;
    else if (RAS_EN && po && m_stk.size() > 0) nxt = m_stk[$];
    else                                       nxt = inc;
    if (RAS_EN && adv) begin
      if (pu && !po && m_stk.size() == DEPTH) e.ovf = 1'b1;
      if (po && !pu && m_stk.size() == 0)     e.unf = 1'b1;
      if (po && m_stk.size() > 0) void'(m_stk.pop_back());
      if (pu) m_stk.push_back(inc);
      if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
    end
    m_pc  = nxt;
    e.pc  = nxt;
    e.cnt = 3'(m_stk.size());
    e.emp = (m_stk.size() == 0);
    sb.push_back(e);
    #1 chk("pc_next", bus.pc_next, nxt);
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic jump(logic [15:0] t);
    drive(0, 16'h0, 1, t, 0, 0, 0);
  endtask

  task automatic spot(string name, logic [15:0] exp_pc);
    @(posedge clk);
    #2 chk(name, bus.pc_cur, exp_pc);
  endtask

  task automatic check_reset_state();
    chk("rst_pc", bus.pc_cur, 16'h0000);
    chk("rst_cnt", bus.ras_count, 0);
    chk("rst_empty", bus.ras_empty, 1);
    chk("rst_ovf", bus.ras_overflow, 0);
    chk("rst_unf", bus.ras_underflow, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_cur", bus.pc_cur, e.pc);
        chk("ras_count", bus.ras_count, e.cnt);
        chk("ras_empty", bus.ras_empty, e.emp);
        chk("ras_overflow", bus.ras_overflow, e.ovf);
        chk("ras_underflow", bus.ras_underflow, e.unf);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t expected finish", $time);
    $fatal(1);
  end

  initial begin : stim
    bus.flush_valid = 0; bus.flush_target = 0;
    bus.redirect_valid = 0; bus.redirect_target = 0;
    bus.stall = 0; bus.ras_push = 0; bus.ras_pop = 0;
    m_pc = 16'h0;
    repeat (2) @(posedge clk);
    #2 check_reset_state();
    reset_n = 1'b1;

    repeat (3) idle();
    spot("seq_pc3", 16'h0003);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    m_pc = 16'h0;
    m_stk.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Flush beats redirect and stall.
    drive(0, 0, 0, 0, 0, 1, 0);
    jump(16'h0010);
    drive(1, 16'h0100, 1, 16'h0200, 1, 0, 0);
    spot("flush_prio", 16'h0100);

    // Drain whatever is on the stack, then calls/returns.
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1);
    jump(16'h0005);
    drive(0, 0, 0, 0, 0, 1, 0);
    jump(16'h0020);
    drive(0, 0, 0, 0, 0, 1, 0);
    jump(16'h0030);
    drive(0, 0, 0, 0, 0, 0, 1);
    spot("ret_1", RAS_EN ? 16'h0021 : 16'h0031);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    jump(16'h0001);
    repeat (5) drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 1);

    jump(16'hFFFF);
    idle();
    spot("wrap", 16'h0000);
    jump(16'h003F);
    drive(0, 0, 0, 0, 0, 1, 0);
    jump(16'h0050);
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Stall and redirect must leave the stack alone even with push/pop asserted.
    drive(0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 1, 16'h0400, 0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) == 0, 16'($urandom),
            $urandom_range(0, 9) == 0, 16'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, i[0], ~i[0]);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #3 chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
